mem_addr_sel: RTL and testbench
===============================

MEM_ADDR_SEL -- requirements
Module: mem_addr_sel

Interface
REQ-001 The module SHALL have parameter AW, default 8: address width in bits.
REQ-002 The module SHALL have parameter NSRC, default 4: number of address sources (source 0 = program counter, source 1 = IR low byte).
REQ-003 The module SHALL have parameter MAXBURST, default 4: maximum beats per access.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 src_addr  input  NSRC x AW  candidate addresses, unpacked array indexed by source.
REQ-007 sel  input  $clog2(NSRC)  source select, sampled only on an accepted start.
REQ-008 fetch  input  1  when 1 on an accepted start, forces source 0 regardless of sel.
REQ-009 start  input  1  request a new access; sampled only in IDLE.
REQ-010 burst_len  input  $clog2(MAXBURST+1)  number of beats, sampled with start.
REQ-011 mem_ack  input  1  memory accepted the current beat.
REQ-012 mem_addr  output  AW  registered address to memory.
REQ-013 mem_req  output  1  registered beat request.
REQ-014 busy  output  1  access in progress.
REQ-015 done  output  1  one-cycle pulse after the final beat is acknowledged.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and REQ.
REQ-017 In IDLE, start=1 at edge t SHALL capture src_addr[fetch ? 0 : sel] into mem_addr, load the beat counter and enter REQ.
REQ-018 At t+1, mem_req=1 and busy=1.
REQ-019 A burst_len of 0 SHALL be treated as 1.
REQ-020 A burst_len above MAXBURST SHALL be clamped to MAXBURST.
REQ-021 If sel >= NSRC with fetch=0, the captured address SHALL be 0.
REQ-022 In REQ with mem_ack=0, mem_addr and mem_req SHALL hold.
REQ-023 In REQ with mem_ack=1 and beats remaining > 1, the counter SHALL decrement and mem_addr SHALL increment by 1 modulo 2^AW (0xFF wraps to 0x00) on the next edge; mem_req stays 1.
REQ-024 In REQ with mem_ack=1 on the last beat, next edge: state IDLE, mem_req=0, busy=0, done=1 for exactly one cycle; mem_addr holds its last value.
REQ-025 start asserted while in REQ SHALL be ignored, with no queuing.
REQ-026 start asserted in the same cycle that done is high SHALL be accepted, because the FSM is in IDLE.
REQ-027 mem_ack while in IDLE SHALL be ignored.
REQ-028 Changes on src_addr, sel or fetch during REQ SHALL NOT affect mem_addr.

Reset
REQ-029 rst_n=0 at an edge SHALL force IDLE, mem_addr=0, mem_req=0, busy=0, done=0 and beat counter=0.
REQ-030 Reset SHALL take priority over all other inputs, including in mid-burst, with no done pulse emitted.
REQ-031 After rst_n returns high, the first start SHALL behave per REQ-017.

Structure
REQ-032 A shared package mem_addr_pkg SHALL hold the state enum (IDLE, REQ) and the source index constants SRC_PC=0 and SRC_IRL=1.
REQ-033 Source selection SHALL be one combinational sub-module, addr_src_mux, parametrised by AW and NSRC, with the fetch override and out-of-range zeroing.
REQ-034 Registers, the counter and the FSM SHALL reside in mem_addr_sel.

Verification
REQ-035 Single beat: src_addr[0]=0x3C, fetch=1, sel=2, burst_len=1, start; ack on 2nd REQ cycle -> mem_addr=0x3C, req held 2 cycles, done pulse 1 cycle, busy low.
REQ-036 Burst with wrap: src_addr[1]=0xFE, fetch=0, sel=1, burst_len=3, ack every cycle -> mem_addr 0xFE, 0xFF, 0x00, then done.
REQ-037 Clamp and zero length: burst_len=7 -> exactly 4 acked beats; burst_len=0 -> exactly 1 beat.
REQ-038 Ignored start: start pulsed mid-burst with a different sel -> address sequence unchanged; back-to-back start during the done cycle is accepted.
REQ-039 Reset mid-burst: rst_n=0 after beat 2 of 4 -> next edge req=0, mem_addr=0, busy=0, no done pulse.
REQ-040 Out-of-range select: NSRC=3, sel=3, fetch=0 -> mem_addr=0x00.

Source files
------------

// File: rtl/mem_addr_pkg.sv
// Shared types and constants for the memory address selector.
// Holds the FSM state encoding, the fixed source indices and an index-width helper.
package mem_addr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   localparam int SRC_PC  = 0;
   localparam int SRC_IRL = 1;

   // Width of an index into n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/addr_src_mux.sv
// Combinational source picker: the fetch flag forces the program counter,
// and a select pointing past the last source yields a zero address.
module addr_src_mux
   import mem_addr_pkg::*;
#(
   parameter int  AW   = 8,
   parameter int  NSRC = 4,
   localparam int SW   = idx_w(NSRC)
) (
   input  logic [AW-1:0] src_addr_i [NSRC],
   input  logic [SW-1:0] sel_i,
   input  logic          fetch_i,
   output logic [AW-1:0] addr_o
);

   always_comb begin
      addr_o = '0;
      if (fetch_i) begin
         addr_o = src_addr_i[SRC_PC];
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (sel_i == SW'(i)) begin
               addr_o = src_addr_i[i];
            end
         end
      end
   end

endmodule

// File: rtl/mem_addr_sel.sv
// Memory address sequencer: captures a source address on start, then issues
// a burst of incrementing beat requests, pulsing done after the last ack.
module mem_addr_sel
   import mem_addr_pkg::*;
#(
   parameter int  AW       = 8,
   parameter int  NSRC     = 4,
   parameter int  MAXBURST = 4,
   localparam int SW       = idx_w(NSRC),
   localparam int BW       = $clog2(MAXBURST + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] src_addr [NSRC],
   input  logic [SW-1:0] sel,
   input  logic          fetch,
   input  logic          start,
   input  logic [BW-1:0] burst_len,
   input  logic          mem_ack,
   output logic [AW-1:0] mem_addr,
   output logic          mem_req,
   output logic          busy,
   output logic          done
);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic          req_q, req_d;
   logic          done_q, done_d;
   logic [AW-1:0] mux_addr;
   logic [BW-1:0] eff_len;

   addr_src_mux #(
      .AW   (AW),
      .NSRC (NSRC)
   ) u_mux (
      .src_addr_i (src_addr),
      .sel_i      (sel),
      .fetch_i    (fetch),
      .addr_o     (mux_addr)
   );

   // Zero-length requests still perform one beat; oversize requests saturate.
   always_comb begin
      if (burst_len == '0) begin
         eff_len = BW'(1);
      end else if (burst_len > BW'(MAXBURST)) begin
         eff_len = BW'(MAXBURST);
      end else begin
         eff_len = burst_len;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = mux_addr;
               cnt_d   = eff_len;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               if (cnt_q > BW'(1)) begin
                  cnt_d  = cnt_q - BW'(1);
                  addr_d = addr_q + AW'(1);
               end else begin
                  cnt_d   = '0;
                  req_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         done_q  <= done_d;
      end
   end

   assign mem_addr = addr_q;
   assign mem_req  = req_q;
   assign busy     = (state_q == REQ);
   assign done     = done_q;

endmodule

// File: tb/tb_mem_addr_sel.sv
// Self-checking bench for mem_addr_sel: directed scenarios plus randomized
// accesses checked against a transaction-level address/beat model.
module tb_mem_addr_sel;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic [7:0] src_addr [4];
   logic [1:0] sel;
   logic       fetch, start, mem_ack;
   logic [2:0] burst_len;
   logic [7:0] mem_addr;
   logic       mem_req, busy, done;

   logic [7:0] src3 [3];
   logic [1:0] sel3;
   logic       fetch3, start3, ack3;
   logic [2:0] bl3;
   logic [7:0] addr3;
   logic       req3, busy3, done3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_addr_sel #(.AW(8), .NSRC(4), .MAXBURST(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_addr  (src_addr),
      .sel       (sel),
      .fetch     (fetch),
      .start     (start),
      .burst_len (burst_len),
      .mem_ack   (mem_ack),
      .mem_addr  (mem_addr),
      .mem_req   (mem_req),
      .busy      (busy),
      .done      (done)
   );

   mem_addr_sel #(.AW(8), .NSRC(3), .MAXBURST(4)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_addr  (src3),
      .sel       (sel3),
      .fetch     (fetch3),
      .start     (start3),
      .burst_len (bl3),
      .mem_ack   (ack3),
      .mem_addr  (addr3),
      .mem_req   (req3),
      .busy      (busy3),
      .done      (done3)
   );

   function automatic logic [7:0] model_base();
      if (fetch) return src_addr[0];
      return src_addr[sel];
   endfunction

   function automatic int model_beats(input logic [2:0] bl);
      if (bl == 3'd0) return 1;
      if (int'(bl) > 4) return 4;
      return int'(bl);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts one access and follows it to the done cycle; random ack gaps.
   task automatic do_access(input logic f, input logic [1:0] s, input logic [2:0] bl,
                            input bit noisy, input bit tail, input string name);
      logic [7:0]  base;
      logic [10:0] got, exp;
      int          n, acked, cycles;
      fetch     = f;
      sel       = s;
      burst_len = bl;
      start     = 1'b1;
      mem_ack   = 1'($urandom_range(0, 1));
      base      = model_base();
      n         = model_beats(bl);
      tick();
      start  = 1'b0;
      acked  = 0;
      cycles = 0;
      while (acked < n && cycles < 200) begin
         exp = {1'b1, 1'b1, 1'b0, base + 8'(acked)};
         got = {mem_req, busy, done, mem_addr};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s beat %0d: req/busy/done/addr got %h required %h", name, acked, got, exp);
         end
         mem_ack = ($urandom_range(0, 3) != 0);
         if (noisy) begin
            for (int i = 0; i < 4; i++) src_addr[i] = 8'($urandom);
            sel       = 2'($urandom);
            fetch     = 1'($urandom);
            burst_len = 3'($urandom);
            start     = 1'($urandom);
         end
         tick();
         if (mem_ack) acked++;
         cycles++;
      end
      start   = 1'b0;
      mem_ack = 1'b0;
      if (acked < n) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: beats acked %0d required %0d", name, acked, n);
      end
      exp = {1'b0, 1'b0, 1'b1, base + 8'(n - 1)};
      got = {mem_req, busy, done, mem_addr};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s done: req/busy/done/addr got %h required %h", name, got, exp);
      end
      if (tail) begin
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         exp = {1'b0, 1'b0, 1'b0, base + 8'(n - 1)};
         got = {mem_req, busy, done, mem_addr};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s idle: req/busy/done/addr got %h required %h", name, got, exp);
         end
      end
      $display("access %s: base %h beats %0d cycles %0d", name, base, n, cycles);
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      start   = 1'b1;
      start3  = 1'b1;
      mem_ack = 1'b1;
      repeat (2) tick();
      checks++;
      if ({mem_req, busy, done, mem_addr, req3, busy3, done3, addr3} !== 22'd0) begin
         errors++;
         $display("FAIL reset: outputs got %h %h required all zero",
                  {mem_req, busy, done, mem_addr}, {req3, busy3, done3, addr3});
      end
      rst_n   = 1'b1;
      start   = 1'b0;
      start3  = 1'b0;
      mem_ack = 1'b0;
      tick();
      checks++;
      if ({mem_req, busy, done, mem_addr} !== 11'd0) begin
         errors++;
         $display("FAIL reset_release: got %h required 000", {mem_req, busy, done, mem_addr});
      end
      $display("reset: done");
   endtask

   task automatic test_single_beat();
      logic [10:0] got;
      logic [10:0] exp [4];
      exp = '{{3'b110, 8'h3C}, {3'b110, 8'h3C}, {3'b001, 8'h3C}, {3'b000, 8'h3C}};
      for (int i = 1; i < 4; i++) src_addr[i] = 8'($urandom);
      src_addr[0] = 8'h3C;
      fetch = 1'b1;
      sel = 2'd2;
      burst_len = 3'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         got = {mem_req, busy, done, mem_addr};
         checks++;
         if (got !== exp[c]) begin
            errors++;
            $display("FAIL single_beat cycle %0d: got %h required %h", c, got, exp[c]);
         end
         mem_ack = (c == 1);
         tick();
      end
      mem_ack = 1'b0;
      $display("single_beat: addr 3c");
   endtask

   task automatic test_burst_wrap();
      logic [7:0]  seq [3];
      logic [10:0] got;
      seq = '{8'hFE, 8'hFF, 8'h00};
      src_addr[1] = 8'hFE;
      src_addr[0] = 8'h11;
      fetch = 1'b0;
      sel = 2'd1;
      burst_len = 3'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      mem_ack = 1'b1;
      for (int b = 0; b < 3; b++) begin
         got = {mem_req, busy, done, mem_addr};
         checks++;
         if (got !== {3'b110, seq[b]}) begin
            errors++;
            $display("FAIL burst_wrap beat %0d: got %h required %h", b, got, {3'b110, seq[b]});
         end
         tick();
      end
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, busy, done, mem_addr} !== 11'b001_0000_0000) begin
         errors++;
         $display("FAIL burst_wrap done: got %h required 100", {mem_req, busy, done, mem_addr});
      end
      tick();
      $display("burst_wrap: fe ff 00");
   endtask

   task automatic test_clamp_zero();
      for (int i = 0; i < 4; i++) src_addr[i] = 8'($urandom);
      do_access(1'b0, 2'($urandom), 3'd7, 1'b0, 1'b1, "clamp7");
      for (int i = 0; i < 4; i++) src_addr[i] = 8'($urandom);
      do_access(1'b0, 2'($urandom), 3'd0, 1'b0, 1'b1, "zero_len");
      do_access(1'b0, 2'($urandom), 3'd5, 1'b0, 1'b1, "clamp5");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) src_addr[i] = 8'($urandom);
      do_access(1'b0, 2'd3, 3'd4, 1'b1, 1'b0, "noisy_burst");
      for (int i = 0; i < 4; i++) src_addr[i] = 8'($urandom);
      do_access(1'b0, 2'd2, 3'd2, 1'b0, 1'b1, "b2b_in_done");
   endtask

   task automatic test_reset_mid_burst();
      logic [10:0] got;
      src_addr[2] = 8'h40;
      fetch = 1'b0;
      sel = 2'd2;
      burst_len = 3'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      mem_ack = 1'b1;
      for (int b = 0; b < 2; b++) begin
         tick();
         checks++;
         if ({mem_req, busy, mem_addr} !== {2'b11, 8'h41 + 8'(b)}) begin
            errors++;
            $display("FAIL rst_mid beat %0d: got %h required %h", b + 1,
                     {mem_req, busy, mem_addr}, {2'b11, 8'h41 + 8'(b)});
         end
      end
      rst_n = 1'b0;
      tick();
      got = {mem_req, busy, done, mem_addr};
      checks++;
      if (got !== 11'd0) begin
         errors++;
         $display("FAIL rst_mid reset: got %h required 000", got);
      end
      rst_n = 1'b1;
      mem_ack = 1'b0;
      tick();
      got = {mem_req, busy, done, mem_addr};
      checks++;
      if (got !== 11'd0) begin
         errors++;
         $display("FAIL rst_mid no_done: got %h required 000", got);
      end
      $display("reset_mid_burst: cleared");
      do_access(1'b0, 2'd1, 3'd2, 1'b0, 1'b1, "after_reset");
   endtask

   task automatic test_out_of_range();
      logic [1:0]  sels [3];
      logic        fets [3];
      logic [7:0]  exps [3];
      src3 = '{8'hA1, 8'hB2, 8'hC3};
      sels = '{2'd3, 2'd2, 2'd3};
      fets = '{1'b0, 1'b0, 1'b1};
      exps = '{8'h00, 8'hC3, 8'hA1};
      bl3 = 3'd1;
      for (int k = 0; k < 3; k++) begin
         sel3 = sels[k];
         fetch3 = fets[k];
         start3 = 1'b1;
         tick();
         start3 = 1'b0;
         checks++;
         if ({req3, busy3, addr3} !== {2'b11, exps[k]}) begin
            errors++;
            $display("FAIL out_of_range case %0d: got %h required %h", k,
                     {req3, busy3, addr3}, {2'b11, exps[k]});
         end
         ack3 = 1'b1;
         tick();
         ack3 = 1'b0;
         checks++;
         if ({req3, busy3, done3} !== 3'b001) begin
            errors++;
            $display("FAIL out_of_range done %0d: got %b required 001", k, {req3, busy3, done3});
         end
         tick();
         $display("out_of_range: sel %0d fetch %0d addr %h", sels[k], fets[k], addr3);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 4; i++) src_addr[i] = 8'($urandom);
         do_access(1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom),
                   (t == 24) || ($urandom_range(0, 1) == 1), "random");
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) src_addr[i] = 8'h00;
      src3 = '{8'h00, 8'h00, 8'h00};
      sel = 2'd0; fetch = 1'b0; start = 1'b0; mem_ack = 1'b0; burst_len = 3'd1;
      sel3 = 2'd0; fetch3 = 1'b0; start3 = 1'b0; ack3 = 1'b0; bl3 = 3'd1;
      test_reset();
      test_single_beat();
      test_burst_wrap();
      test_clamp_zero();
      test_back_to_back();
      test_reset_mid_burst();
      test_out_of_range();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
